ms_array_ctrl: RTL and testbench

Sequencer that drives a row of `NUM_MS` multiplier switches from one upstream valid/ready data stream. For each job it runs three phases:
- loads one stationary operand into each switch, in index order;
- broadcasts a programmed number of streaming operands to all switches;
- waits out the multiplier pipeline, then signals completion.

It sits between the operand-distribution FIFO and the multiplier-switch array, and owns their `i_valid`, `i_stationary` and `i_data` inputs.

---
 rtl/sigma_ctrl_pkg.sv | 6 +
 rtl/ms_drain_timer.sv | 17 +
 rtl/ms_array_ctrl.sv | 116 +++++++++++
 tb/tb_ms_array_ctrl.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/sigma_ctrl_pkg.sv
// sigma_ctrl_pkg: shared state encoding and constants for the multiplier-switch sequencer.
package sigma_ctrl_pkg;
   typedef enum logic [2:0] {MS_IDLE, MS_LOAD, MS_STREAM, MS_DRAIN, MS_DONE} ms_state_e;
   // Extra drain cycle covering the valid register inside each switch.
   localparam int MS_DRAIN_EXTRA = 1;
endpackage

// File: rtl/ms_drain_timer.sv
// ms_drain_timer: loadable down-counter; expire_o pulses in the len_i-th cycle after load.
module ms_drain_timer #(
   parameter int W = 3
) (
   input  logic         CLK,
   input  logic         rst,
   input  logic         load_i,
   input  logic [W-1:0] len_i,
   output logic         expire_o
);
   logic [W-1:0] cnt_q, cnt_d;
   always_comb cnt_d = load_i ? len_i : (cnt_q != '0 ? cnt_q - W'(1) : cnt_q);
   always_ff @(posedge CLK or posedge rst)
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   assign expire_o = cnt_q == W'(1);
endmodule

// File: rtl/ms_array_ctrl.sv
// ms_array_ctrl: loads stationary operands, streams broadcasts, drains the multiplier pipeline.
// Optional stall counter output enabled by MS_ARRAY_CTRL_PERF_CNT_EN.
module ms_array_ctrl
   import sigma_ctrl_pkg::*;
#(
   parameter int NUM_MS   = 8,
   parameter int DATA_W   = 16,
   parameter int MULT_LAT = 3,
   parameter int CNT_W    = 16
) (
   input  logic              CLK,
   input  logic              rst,
   input  logic              i_start,
   input  logic [CNT_W-1:0]  i_num_stream,
   input  logic              i_data_valid,
   input  logic [DATA_W-1:0] i_data,
   output logic              o_data_ready,
   output logic [NUM_MS-1:0] o_ms_valid,
   output logic [NUM_MS-1:0] o_ms_stationary,
   output logic [DATA_W-1:0] o_ms_data,
   output logic              o_busy,
   output logic              o_done
`ifdef MS_ARRAY_CTRL_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]  o_stall_cnt
`endif
);
   localparam int IW = NUM_MS > 1 ? $clog2(NUM_MS) : 1;
   localparam int DRAIN_LEN = MULT_LAT + MS_DRAIN_EXTRA;
   localparam int TW = $clog2(DRAIN_LEN + 1);
   ms_state_e state_q, state_d;
   logic [CNT_W-1:0]  num_q, num_d, beat_q, beat_d, beat_inc;
   logic [IW-1:0]     idx_q, idx_d;
   logic [NUM_MS-1:0] vld_q, vld_d, stat_q, stat_d, onehot;
   logic [DATA_W-1:0] dat_q, dat_d;
   logic acc, load_last, stream_last, drain_load, drain_exp;
   assign o_data_ready = state_q == MS_LOAD || state_q == MS_STREAM;
   assign o_busy       = state_q != MS_IDLE;
   assign o_done       = state_q == MS_DONE;
   assign acc          = i_data_valid & o_data_ready;
   assign load_last    = idx_q == IW'(NUM_MS - 1);
   assign beat_inc     = beat_q + CNT_W'(1);
   assign stream_last  = beat_inc == num_q;
   assign onehot       = NUM_MS'(1) << idx_q;
   assign drain_load   = state_q == MS_STREAM && acc && stream_last;
   always_comb begin
      state_d = state_q;
      num_d   = num_q;
      beat_d  = beat_q;
      idx_d   = idx_q;
      vld_d   = '0;
      stat_d  = '0;
      dat_d   = dat_q;
      unique case (state_q)
         MS_IDLE: if (i_start) begin
            state_d = MS_LOAD;
            num_d   = i_num_stream;
            beat_d  = '0;
            idx_d   = '0;
         end
         MS_LOAD: if (acc) begin
            vld_d  = onehot;
            stat_d = onehot;
            dat_d  = i_data;
            idx_d  = idx_q + IW'(1);
            if (load_last) state_d = num_q != '0 ? MS_STREAM : MS_DONE;
         end
         MS_STREAM: if (acc) begin
            vld_d  = '1;
            dat_d  = i_data;
            beat_d = beat_inc;
            if (stream_last) state_d = MS_DRAIN;
         end
         MS_DRAIN: if (drain_exp) state_d = MS_DONE;
         MS_DONE:  state_d = MS_IDLE;
         default:  state_d = MS_IDLE;
      endcase
   end
   always_ff @(posedge CLK or posedge rst)
      if (rst) begin
         state_q <= MS_IDLE;
         num_q   <= '0;
         beat_q  <= '0;
         idx_q   <= '0;
         vld_q   <= '0;
         stat_q  <= '0;
         dat_q   <= '0;
      end else begin
         state_q <= state_d;
         num_q   <= num_d;
         beat_q  <= beat_d;
         idx_q   <= idx_d;
         vld_q   <= vld_d;
         stat_q  <= stat_d;
         dat_q   <= dat_d;
      end
   assign o_ms_valid      = vld_q;
   assign o_ms_stationary = stat_q;
   assign o_ms_data       = dat_q;
   ms_drain_timer #(.W(TW)) u_drain (
      .CLK      (CLK),
      .rst      (rst),
      .load_i   (drain_load),
      .len_i    (TW'(DRAIN_LEN)),
      .expire_o (drain_exp)
   );
`ifdef MS_ARRAY_CTRL_PERF_CNT_EN
   logic [CNT_W-1:0] stall_q, stall_d;
   always_comb stall_d = (state_q == MS_IDLE && i_start) ? '0 :
                         (o_data_ready && !i_data_valid && stall_q != '1) ? stall_q + CNT_W'(1) : stall_q;
   always_ff @(posedge CLK or posedge rst)
      if (rst) stall_q <= '0;
      else     stall_q <= stall_d;
   assign o_stall_cnt = stall_q;
`endif
endmodule

// File: tb/tb_ms_array_ctrl.sv
// tb_ms_array_ctrl: directed jobs with a scoreboard of expected switch-port values.
module tb_ms_array_ctrl;
   localparam int NUM = 4, DW = 16, LAT = 3, CW = 16;
   logic CLK = 1'b0, rst = 1'b1, i_start = 1'b0, i_data_valid = 1'b0;
   logic [CW-1:0] i_num_stream = '0;
   logic [DW-1:0] i_data = '0;
   logic o_data_ready, o_busy, o_done;
   logic [NUM-1:0] o_ms_valid, o_ms_stationary;
   logic [DW-1:0] o_ms_data;
`ifdef MS_ARRAY_CTRL_PERF_CNT_EN
   logic [CW-1:0] o_stall_cnt;
`endif
   typedef struct packed {logic [NUM-1:0] v; logic [NUM-1:0] s; logic [DW-1:0] d;} exp_t;
   exp_t sb[$];
   int nvec = 0, nerr = 0;
   logic [DW-1:0] last_d = '0;

   ms_array_ctrl #(.NUM_MS(NUM), .DATA_W(DW), .MULT_LAT(LAT), .CNT_W(CW)) dut (
      .CLK(CLK), .rst(rst), .i_start(i_start), .i_num_stream(i_num_stream),
      .i_data_valid(i_data_valid), .i_data(i_data), .o_data_ready(o_data_ready),
      .o_ms_valid(o_ms_valid), .o_ms_stationary(o_ms_stationary), .o_ms_data(o_ms_data),
      .o_busy(o_busy), .o_done(o_done)
`ifdef MS_ARRAY_CTRL_PERF_CNT_EN
      , .o_stall_cnt(o_stall_cnt)
`endif
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_valid"}, 64'(o_ms_valid), 0);
      chk({tag, "_stat"}, 64'(o_ms_stationary), 0);
      chk({tag, "_data"}, 64'(o_ms_data), 0);
      chk({tag, "_ready"}, 64'(o_data_ready), 0);
      chk({tag, "_busy"}, 64'(o_busy), 0);
      chk({tag, "_done"}, 64'(o_done), 0);
   endtask

   // One cycle of upstream traffic; b is the beat index within the job.
   task automatic drive(input bit v, input logic [DW-1:0] d, input int b);
      exp_t e;
      chk("ready_active", 64'(o_data_ready), 1);
      i_data_valid = v;
      i_data = d;
      if (!v) sb.push_back('{v: '0, s: '0, d: last_d});
      else if (b < NUM) sb.push_back('{v: NUM'(1) << b, s: NUM'(1) << b, d: d});
      else sb.push_back('{v: '1, s: '0, d: d});
      if (v) last_d = d;
      @(negedge CLK);
      e = sb.pop_front();
      chk("ms_valid", 64'(o_ms_valid), 64'(e.v));
      chk("ms_stat", 64'(o_ms_stationary), 64'(e.s));
      chk("ms_data", 64'(o_ms_data), 64'(e.d));
   endtask

   task automatic job(input int n, input int bub_each, input int bub_first, input bit start_mid,
                      input int rst_after, input logic [DW-1:0] base);
      int e, bub, exp_e, ndone;
      i_start = 1'b1;
      i_num_stream = CW'(n);
      i_data_valid = 1'b0;
      @(negedge CLK);
      i_start = 1'b0;
      e = 0;
      bub = 0;
      chk("busy_after_start", 64'(o_busy), 1);
`ifdef MS_ARRAY_CTRL_PERF_CNT_EN
      chk("stall_cleared", 64'(o_stall_cnt), 0);
`endif
      for (int b = 0; b < NUM + n; b++) begin
         for (int k = 0; k < bub_each + (b == 0 ? bub_first : 0); k++) begin
            drive(1'b0, 16'hBEEF, b);
            e++;
            bub++;
         end
         if (start_mid && b == NUM) begin
            i_start = 1'b1;
            i_num_stream = CW'(9);
         end
         drive(1'b1, base + DW'(b + 1), b);
         i_start = 1'b0;
         e++;
         if (b == rst_after) begin
            rst = 1'b1;
            #1;
            chk_idle_outputs("rst_mid");
            @(negedge CLK);
            rst = 1'b0;
            i_data_valid = 1'b0;
            sb.delete();
            last_d = '0;
            ndone = 0;
            for (int k = 0; k < 20; k++) begin
               @(negedge CLK);
               if (o_done) ndone++;
            end
            chk("no_done_after_rst", 64'(ndone), 0);
            chk("idle_after_rst", 64'(o_busy), 0);
            return;
         end
      end
      exp_e = n > 0 ? NUM + n + bub + LAT + 1 : NUM + bub;
      // Valid data during drain must be ignored.
      i_data_valid = 1'b1;
      i_data = 16'hDEAD;
      for (int k = 0; k < 64 && !o_done; k++) begin
         chk("drain_ready", 64'(o_data_ready), 0);
         @(negedge CLK);
         e++;
         chk("drain_valid", 64'(o_ms_valid), 0);
         chk("drain_data", 64'(o_ms_data), 64'(last_d));
      end
      chk("done_edge", 64'(e), 64'(exp_e));
      chk("done_high", 64'(o_done), 1);
`ifdef MS_ARRAY_CTRL_PERF_CNT_EN
      chk("stall_cnt", 64'(o_stall_cnt), 64'(bub));
`endif
      ndone = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge CLK);
         if (o_done) ndone++;
      end
      chk("done_single", 64'(ndone), 0);
      chk("idle_after_done", 64'(o_busy), 0);
      chk("idle_data_ignored", 64'(o_ms_valid), 0);
      i_data_valid = 1'b0;
   endtask

   initial begin
      @(negedge CLK);
      @(negedge CLK);
      chk_idle_outputs("reset");
      rst = 1'b0;
      i_data_valid = 1'b1;
      i_data = 16'h0055;
      @(negedge CLK);
      @(negedge CLK);
      chk_idle_outputs("idle_valid");
      i_data_valid = 1'b0;
      job(3, 0, 0, 1'b0, -1, 16'h0000);
      job(3, 1, 0, 1'b0, -1, 16'h0000);
      job(0, 0, 0, 1'b0, -1, 16'h0100);
      job(3, 0, 0, 1'b1, -1, 16'h0200);
      job(3, 0, 0, 1'b0, NUM, 16'h0300);
      job(3, 0, 0, 1'b0, -1, 16'h0400);
      job(0, 0, 5, 1'b0, -1, 16'h0500);
      job(2, 0, 2, 1'b0, -1, DW'($urandom_range(0, 16'hF000)));
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
